// File: rtl/dvp_pkg.sv
// Shared types for the DVP capture front end: FSM states, beat sideband
// bits and the bytes-per-beat helper.
package dvp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DROP     = 2'd3
    } dvp_state_e;

    typedef struct packed {
        logic tuser;
        logic tlast;
    } dvp_side_t;

    function automatic int beat_bytes(input int dvp_width, input int axis_width);
        return axis_width / dvp_width;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output word.
// The output register counts toward the depth, so 'full' means P_DEPTH words held.
module sync_fifo #(
    parameter int P_WIDTH = 66,
    parameter int P_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        mem_cnt;
    logic [AW:0]        occ;
    logic               rd_valid;
    logic               pop;
    logic               load;
    logic               push;

    assign occ   = mem_cnt + {{AW{1'b0}}, rd_valid};
    assign full  = (occ == (AW+1)'(P_DEPTH));
    assign empty = !rd_valid;
    assign pop   = rd_valid && rd_en;
    assign load  = (mem_cnt != '0) && (!rd_valid || pop);
    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dvp_window_packer.sv
// DVP sensor capture: crop window, frame decimation, byte packing into
// AXI-Stream beats with tuser/tlast, output buffer and frame/overflow stats.
module dvp_window_packer
    import dvp_pkg::*;
#(
    parameter int P_DVP_DATA_WIDTH  = 8,
    parameter int P_AXIS_DATA_WIDTH = 64,
    parameter int P_FIFO_DEPTH      = 16,
    parameter int P_CNT_WIDTH       = 12
) (
    input  logic                         i_dvp_pclk,
    input  logic                         i_dvp_rstn,
    input  logic                         i_dvp_vsync,
    input  logic                         i_dvp_href,
    input  logic [P_DVP_DATA_WIDTH-1:0]  i_dvp_data,
    input  logic                         i_en,
    input  logic [P_CNT_WIDTH-1:0]       i_x_start,
    input  logic [P_CNT_WIDTH-1:0]       i_x_end,
    input  logic [P_CNT_WIDTH-1:0]       i_y_start,
    input  logic [P_CNT_WIDTH-1:0]       i_y_end,
    input  logic [3:0]                   i_frame_skip,
    input  logic                         i_clr_stat,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic [15:0]                  o_frame_cnt,
    output logic [15:0]                  o_ovf_cnt,
    output logic [1:0]                   o_dbg_state
);

    localparam int K      = beat_bytes(P_DVP_DATA_WIDTH, P_AXIS_DATA_WIDTH);
    localparam int LANE_W = (K > 1) ? $clog2(K) : 1;
    localparam int FW     = P_AXIS_DATA_WIDTH + 2;

    dvp_state_e                  state, state_nxt;
    logic                        vsync_r, vsync_d, href_r, href_d;
    logic [P_DVP_DATA_WIDTH-1:0] data_r;
    logic                        sof, vs_rise, href_fall;
    logic [P_CNT_WIDTH-1:0]      x_start_q, x_end_q, y_start_q, y_end_q;
    logic [P_CNT_WIDTH-1:0]      col, line;
    logic [3:0]                  skip_cnt;
    logic [LANE_W-1:0]           lane;
    logic [P_AXIS_DATA_WIDTH-1:0] acc, acc_ins, beat_data;
    logic                        beat_vld, beat_last;
    logic                        keep, close;
    logic                        frame_wrote;
    logic                        fifo_full, fifo_empty, fifo_pop;
    logic                        wr_try, wr_ok, ovf_hit, frame_done;
    dvp_side_t                   wr_side, rd_side;
    logic [FW-1:0]               rd_word;

    assign sof       = vsync_d && !vsync_r;
    assign vs_rise   = vsync_r && !vsync_d;
    assign href_fall = href_d && !href_r;

    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) begin
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
            href_r  <= 1'b0;
            href_d  <= 1'b0;
            data_r  <= '0;
        end else begin
            vsync_r <= i_dvp_vsync;
            vsync_d <= vsync_r;
            href_r  <= i_dvp_href;
            href_d  <= href_r;
            data_r  <= i_dvp_data;
        end
    end

    // Stream handshake: a beat moves when tvalid && tready; tvalid comes only
    // from buffer occupancy and tdata/tuser/tlast hold until the beat moves.
    assign fifo_pop   = m_axis_tvalid && m_axis_tready;
    assign wr_try     = beat_vld && (state == ST_ACTIVE);
    assign wr_ok      = wr_try && (!fifo_full || fifo_pop);
    assign ovf_hit    = wr_try && !wr_ok;
    assign frame_done = (state == ST_ACTIVE) && vs_rise && (frame_wrote || wr_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (vsync_r) state_nxt = ST_WAIT_SOF;
            ST_WAIT_SOF: if (sof) state_nxt = (i_en && skip_cnt == 4'd0) ? ST_ACTIVE : ST_DROP;
            ST_ACTIVE: begin
                if (vs_rise)      state_nxt = ST_WAIT_SOF;
                else if (ovf_hit) state_nxt = ST_DROP;
            end
            ST_DROP:     if (vs_rise) state_nxt = ST_WAIT_SOF;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    assign o_dbg_state = state;

    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) begin
            skip_cnt  <= 4'd0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_start_q <= '0;
            y_end_q   <= '0;
        end else if (sof && state != ST_IDLE) begin
            skip_cnt  <= (skip_cnt == 4'd0) ? i_frame_skip : skip_cnt - 4'd1;
            x_start_q <= i_x_start;
            x_end_q   <= i_x_end;
            y_start_q <= i_y_start;
            y_end_q   <= i_y_end;
        end
    end

    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) begin
            col  <= '0;
            line <= '0;
        end else begin
            col <= href_r ? col + P_CNT_WIDTH'(1) : '0;
            if (sof)            line <= '0;
            else if (href_fall) line <= line + P_CNT_WIDTH'(1);
        end
    end

    assign keep  = (state == ST_ACTIVE) && href_r &&
                   (col >= x_start_q) && (col <= x_end_q) &&
                   (line >= y_start_q) && (line <= y_end_q);
    assign close = keep && ((lane == LANE_W'(K-1)) || (col == x_end_q));

    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < K; i++) begin
            if (lane == LANE_W'(i)) acc_ins[i*P_DVP_DATA_WIDTH +: P_DVP_DATA_WIDTH] = data_r;
        end
    end

    // Lanes are cleared after each closing beat so a short beat carries zeros.
    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) begin
            lane      <= '0;
            acc       <= '0;
            beat_vld  <= 1'b0;
            beat_data <= '0;
            beat_last <= 1'b0;
        end else begin
            beat_vld <= close;
            if (sof) begin
                lane <= '0;
                acc  <= '0;
            end else if (close) begin
                beat_data <= acc_ins;
                beat_last <= (col == x_end_q);
                lane      <= '0;
                acc       <= '0;
            end else if (keep) begin
                acc  <= acc_ins;
                lane <= lane + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge i_dvp_pclk or negedge i_dvp_rstn) begin
        if (!i_dvp_rstn) begin
            frame_wrote <= 1'b0;
            o_frame_cnt <= 16'd0;
            o_ovf_cnt   <= 16'd0;
        end else begin
            if (sof)        frame_wrote <= 1'b0;
            else if (wr_ok) frame_wrote <= 1'b1;
            if (i_clr_stat) begin
                o_frame_cnt <= 16'd0;
                o_ovf_cnt   <= 16'd0;
            end else begin
                if (frame_done) o_frame_cnt <= o_frame_cnt + 16'd1;
                if (ovf_hit && o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;
            end
        end
    end

    assign wr_side.tuser = !frame_wrote;
    assign wr_side.tlast = beat_last;

    sync_fifo #(
        .P_WIDTH (FW),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_dvp_pclk),
        .rst_n   (i_dvp_rstn),
        .wr_en   (wr_try),
        .wr_data ({wr_side, beat_data}),
        .rd_en   (m_axis_tready),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_side       = rd_word[FW-1 -: 2];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = rd_word[P_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tuser  = rd_side.tuser;
    assign m_axis_tlast  = rd_side.tlast;

endmodule

// File: tb/tb_dvp_window_packer.sv
// Directed bench for dvp_window_packer: frame driver tasks, a beat
// scoreboard with hand-computed expectations, and a one-line report.
module tb_dvp_window_packer;

    localparam int DW = 8;
    localparam int AW = 64;
    localparam int FD = 4;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync, href;
    logic [DW-1:0] dvp_data;
    logic          en;
    logic [CW-1:0] x_start, x_end, y_start, y_end;
    logic [3:0]    frame_skip;
    logic          clr_stat;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [AW-1:0] m_axis_tdata;
    logic [15:0]   frame_cnt, ovf_cnt;
    logic [1:0]    dbg_state;

    int            checks = 0;
    int            errors = 0;
    logic [71:0]   exp_q[$];
    logic [71:0]   exp_beat_v;

    always #5 clk = ~clk;

    dvp_window_packer #(
        .P_DVP_DATA_WIDTH  (DW),
        .P_AXIS_DATA_WIDTH (AW),
        .P_FIFO_DEPTH      (FD),
        .P_CNT_WIDTH       (CW)
    ) dut (
        .i_dvp_pclk    (clk),
        .i_dvp_rstn    (rst_n),
        .i_dvp_vsync   (vsync),
        .i_dvp_href    (href),
        .i_dvp_data    (dvp_data),
        .i_en          (en),
        .i_x_start     (x_start),
        .i_x_end       (x_end),
        .i_y_start     (y_start),
        .i_y_end       (y_end),
        .i_frame_skip  (frame_skip),
        .i_clr_stat    (clr_stat),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .o_frame_cnt   (frame_cnt),
        .o_ovf_cnt     (ovf_cnt),
        .o_dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] beat_of(input logic [7:0] b, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = b + 8'(i);
        return r;
    endfunction

    function automatic logic [71:0] mk_beat(input logic tuser, input logic tlast, input logic [63:0] d);
        return {6'b0, tuser, tlast, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_window(input int xs, input int xe, input int ys, input int ye);
        x_start = CW'(xs);
        x_end   = CW'(xe);
        y_start = CW'(ys);
        y_end   = CW'(ye);
    endtask

    task automatic send_line(input int n_bytes, input logic [7:0] first);
        for (int c = 0; c < n_bytes; c++) begin
            href     = 1'b1;
            dvp_data = first + 8'(c);
            step();
        end
        href     = 1'b0;
        dvp_data = '0;
        repeat (4) step();
    endtask

    // Blanking, SOF, n_lines of n_bytes counting up from base, then vsync rises
    // to close the frame; clr_at_end lines a clear pulse up with the frame-end edge.
    task automatic send_frame(input int n_lines, input int n_bytes, input logic [7:0] base,
                              input bit clr_at_end);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) step();
        vsync = 1'b0;
        repeat (3) step();
        for (int l = 0; l < n_lines; l++) send_line(n_bytes, base + 8'(l * n_bytes));
        vsync = 1'b1;
        step();
        if (clr_at_end) clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 72'(exp_q.size()), 72'(0));
    endtask

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 72'(m_axis_tvalid), 72'(0));
            end else begin
                exp_beat_v = exp_q.pop_front();
                check("beat", {6'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_beat_v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        vsync         = 1'b0;
        href          = 1'b0;
        dvp_data      = '0;
        en            = 1'b1;
        frame_skip    = 4'd0;
        clr_stat      = 1'b0;
        m_axis_tready = 1'b1;
        set_window(0, 7, 0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 72'(m_axis_tvalid), 72'(0));
        check("rst_tdata",  72'(m_axis_tdata),  72'(0));
        check("rst_tuser",  72'(m_axis_tuser),  72'(0));
        check("rst_tlast",  72'(m_axis_tlast),  72'(0));
        check("rst_frames", 72'(frame_cnt),     72'(0));
        check("rst_ovf",    72'(ovf_cnt),       72'(0));
        check("rst_state",  72'(dbg_state),     72'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // Full 8x2 window: two beats, tuser only on the first.
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'h0706050403020100));
        exp_q.push_back(mk_beat(1'b0, 1'b1, 64'h0F0E0D0C0B0A0908));
        send_frame(2, 8, 8'h00, 1'b0);
        wait_drain("full_window");
        check("full_window_frames", 72'(frame_cnt), 72'(1));
        check("full_window_ovf",    72'(ovf_cnt),   72'(0));

        // Crop x 2..4 on line 1 of a 4-line frame: short beat, upper lanes zero.
        set_window(2, 4, 1, 1);
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'h00000000002C2B2A));
        send_frame(4, 8, 8'h20, 1'b0);
        wait_drain("crop");
        check("crop_frames", 72'(frame_cnt), 72'(2));

        // Decimation by 3: of six frames only the first and fourth come out.
        set_window(0, 7, 0, 0);
        frame_skip = 4'd2;
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'h0706050403020100));
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'h3736353433323130));
        for (int f = 0; f < 6; f++) begin
            if (f == 5) frame_skip = 4'd0;
            send_frame(1, 8, 8'(f * 16), 1'b0);
        end
        wait_drain("skip");
        check("skip_frames", 72'(frame_cnt), 72'(4));

        // Stalled sink: four beats fit, the fifth overflows and drops the frame.
        set_window(0, 7, 0, 7);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(i == 0, 1'b1, beat_of(8'h40 + 8'(i * 8), 8)));
        send_frame(8, 8, 8'h40, 1'b0);
        check("ovf_count",  72'(ovf_cnt),       72'(1));
        check("ovf_frames", 72'(frame_cnt),     72'(4));
        check("ovf_tvalid", 72'(m_axis_tvalid), 72'(1));
        check("ovf_hold",   72'(m_axis_tdata),  72'(beat_of(8'h40, 8)));
        m_axis_tready = 1'b1;
        wait_drain("ovf_buffered");
        for (int i = 0; i < 8; i++)
            exp_q.push_back(mk_beat(i == 0, 1'b1, beat_of(8'h80 + 8'(i * 8), 8)));
        send_frame(8, 8, 8'h80, 1'b0);
        wait_drain("after_ovf");
        check("after_ovf_frames", 72'(frame_cnt), 72'(5));
        check("after_ovf_ovf",    72'(ovf_cnt),   72'(1));

        // Reset in the middle of line 0; the rest of that frame must stay silent.
        set_window(0, 7, 0, 1);
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (3) step();
        for (int c = 0; c < 4; c++) begin
            href     = 1'b1;
            dvp_data = 8'h90 + 8'(c);
            step();
        end
        rst_n = 1'b0;
        for (int c = 4; c < 6; c++) begin
            dvp_data = 8'h90 + 8'(c);
            step();
        end
        @(negedge clk);
        check("mid_rst_tvalid", 72'(m_axis_tvalid), 72'(0));
        check("mid_rst_tdata",  72'(m_axis_tdata),  72'(0));
        check("mid_rst_frames", 72'(frame_cnt),     72'(0));
        check("mid_rst_ovf",    72'(ovf_cnt),       72'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 6; c < 8; c++) begin
            dvp_data = 8'h90 + 8'(c);
            step();
        end
        href     = 1'b0;
        dvp_data = '0;
        repeat (4) step();
        send_line(8, 8'h98);
        @(negedge clk);
        check("post_rst_state", 72'(dbg_state), 72'(0));
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'hA7A6A5A4A3A2A1A0));
        exp_q.push_back(mk_beat(1'b0, 1'b1, 64'hAFAEADACABAAA9A8));
        step();
        send_frame(2, 8, 8'hA0, 1'b0);
        wait_drain("post_rst");
        check("post_rst_frames", 72'(frame_cnt), 72'(1));

        // Clear pulse on the same edge as a counted frame end wins over the increment.
        set_window(0, 7, 0, 7);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(i == 0, 1'b1, beat_of(8'hC0 + 8'(i * 8), 8)));
        send_frame(8, 8, 8'hC0, 1'b0);
        check("clr_pre_ovf", 72'(ovf_cnt), 72'(1));
        m_axis_tready = 1'b1;
        wait_drain("clr_ovf");
        set_window(0, 7, 0, 0);
        exp_q.push_back(mk_beat(1'b1, 1'b1, 64'h1716151413121110));
        send_frame(1, 8, 8'h10, 1'b1);
        wait_drain("clr");
        @(negedge clk);
        check("clr_frames", 72'(frame_cnt), 72'(0));
        check("clr_ovf",    72'(ovf_cnt),   72'(0));

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
